instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 102 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives a combinational instruction memory
// from a PC register and queues {instruction, pc} pairs in a small FIFO
// for decode. Supports redirect (flush + PC reload) and level halt.
module instr_fetch_ctrl #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt_req,
   output logic            halted
);

   localparam int unsigned PW = $clog2(BUF_DEPTH);
   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] instr_mem [BUF_DEPTH];
   logic [XLEN-1:0] pc_mem    [BUF_DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count;
   logic            full, empty, push, pop;

   assign full  = (count == CW'(BUF_DEPTH));
   assign empty = (count == '0);
   assign pop   = !empty && out_ready;
   assign push  = (state == FETCH) && !redirect_valid && (!full || pop);

   assign imem_addr = pc;
   assign out_valid = !empty;
   assign out_instr = instr_mem[rd_ptr];
   assign out_pc    = pc_mem[rd_ptr];
   assign halted    = (state == HALT);

   // Next-state logic; redirect overrides a pending halt request
   always_comb begin
      state_nxt = state;
      unique case (state)
         BOOT:  state_nxt = FETCH;
         FETCH: if (halt_req && !redirect_valid) state_nxt = HALT;
         HALT:  if (!halt_req || redirect_valid) state_nxt = FETCH;
         default: state_nxt = BOOT;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_nxt;
   end

   // Fetch PC: word-aligned redirect target wins over sequential advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              pc <= RESET_PC;
      else if (redirect_valid) pc <= redirect_pc & ~XLEN'(3);
      else if (push)           pc <= pc + XLEN'(4);
   end

   // Fetch buffer storage; written only on push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
         end
      end else if (push) begin
         instr_mem[wr_ptr] <= imem_instr;
         pc_mem[wr_ptr]    <= pc;
      end
   end

   // Buffer pointers and occupancy; redirect empties the buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench: queue-based reference model of the fetch buffer,
// directed scenarios followed by random traffic; second instance checks
// PC wrap from a high reset address with a 4-deep buffer.
module tb_instr_fetch_ctrl;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr, imem_instr;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_pc;
   logic        redirect_valid, halt_req, halted;
   logic [31:0] redirect_pc;

   logic        rst_b;
   logic [31:0] imem_addr_b, imem_instr_b;
   logic        out_valid_b;
   logic [31:0] out_instr_b, out_pc_b;
   logic        halted_b;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_pc;
   int          m_state; // 0 boot, 1 fetch, 2 halt

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return 32'h1000 + (a >> 2);
   endfunction

   assign imem_instr   = rom(imem_addr);
   assign imem_instr_b = rom(imem_addr_b);

   instr_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .halted(halted)
   );

   instr_fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut_b (
      .clk(clk), .rst_n(rst_b), .imem_addr(imem_addr_b), .imem_instr(imem_instr_b),
      .out_valid(out_valid_b), .out_ready(1'b1), .out_instr(out_instr_b),
      .out_pc(out_pc_b), .redirect_valid(1'b0), .redirect_pc(32'h0),
      .halt_req(1'b0), .halted(halted_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc    = 32'h0;
      m_state = 0;
   endtask

   // One clock of the reference: pop, then flush/reload or push, then state
   task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rpc,
                             input logic hr);
      bit was_full, popped;
      was_full = (q.size() == DEPTH);
      popped   = (q.size() != 0) && rdy;
      if (popped) void'(q.pop_front());
      if (rv) begin
         q.delete();
         m_pc    = rpc & 32'hFFFF_FFFC;
         m_state = 1;
      end else begin
         if (m_state == 1 && (!was_full || popped)) begin
            q.push_back('{instr: rom(m_pc), pc: m_pc});
            m_pc = m_pc + 32'd4;
         end
         if (m_state == 0)               m_state = 1;
         else if (m_state == 1 && hr)    m_state = 2;
         else if (m_state == 2 && !hr)   m_state = 1;
      end
   endtask

   task automatic check_model();
      chk("valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
         chk("out_pc", out_pc, q[0].pc);
         chk("out_instr", out_instr, q[0].instr);
      end
      chk("imem_addr", imem_addr, m_pc);
      chk("halted", {31'b0, halted}, {31'b0, m_state == 2});
   endtask

   task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc, input logic hr);
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt_req       = hr;
      @(posedge clk);
      model_step(rdy, rv, rpc, hr);
      #1;
      check_model();
   endtask

   initial begin
      rst_n = 1'b0; rst_b = 1'b0;
      out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
      model_reset();
      #1;
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming with decode always ready
      cyc(1, 0, 0, 0);
      chk("boot_no_valid", {31'b0, out_valid}, 32'd0);
      cyc(1, 0, 0, 0);
      chk("first_pc", out_pc, 32'h0);
      chk("first_instr", out_instr, 32'h1000);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);

      // Back-pressure: buffer fills, fetch address stalls
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);

      // Redirect while full
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      cyc(0, 1, 32'h203, 0);
      chk("redir_flush", {31'b0, out_valid}, 32'd0);
      chk("redir_addr", imem_addr, 32'h200);
      cyc(1, 0, 0, 0);
      chk("redir_head", out_pc, 32'h200);

      // Halt with two buffered entries draining
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);

      // Halt and redirect in the same cycle
      cyc(1, 1, 32'h40, 1);
      chk("hr_redir_halted", {31'b0, halted}, 32'd0);
      chk("hr_redir_addr", imem_addr, 32'h40);
      cyc(1, 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic rdy, rv, hr;
         logic [31:0] rpc;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 19) == 0);
         hr  = ($urandom_range(0, 5) == 0);
         rpc = $urandom;
         cyc(rdy, rv, rpc, hr);
      end

      // Asynchronous reset mid-stream
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_addr", imem_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);

      // High reset PC wraps through zero
      @(negedge clk);
      rst_b = 1'b1;
      @(posedge clk); #1;
      chk("b_boot_valid", {31'b0, out_valid_b}, 32'd0);
      @(posedge clk); #1;
      chk("b_pc0", out_pc_b, 32'hFFFF_FFF8);
      @(posedge clk); #1;
      chk("b_pc1", out_pc_b, 32'hFFFF_FFFC);
      @(posedge clk); #1;
      chk("b_pc2", out_pc_b, 32'h0000_0000);
      chk("b_instr2", out_instr_b, 32'h1000);
      rst_b = 1'b0;
      #1;
      chk("b_midrst_valid", {31'b0, out_valid_b}, 32'd0);
      chk("b_midrst_addr", imem_addr_b, 32'hFFFF_FFF8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
